mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator-side load/store controller for the multi-cycle CPU's MEM stage; sole master of the byte-addressed, big-endian data RAM.
- Accepts one word, halfword or byte load/store per request over a req/ack handshake.
- Drives the RAM address, write data, read enable and write enable. Sub-word stores are done as read-modify-write, because the RAM always writes 4 bytes.
- Returns the aligned, sign- or zero-extended load data with a one-cycle ack.

Parameters:
- RAM_BYTES, 61, byte depth of the data RAM. An access touching byte address >= RAM_BYTES is out of range.
- ADDR_W, 32, width of the CPU address and RAM address buses.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 word, 01 halfword, 10 byte, 11 reserved (treated as err).
- sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  ADDR_W  CPU byte address.
- wdata  in  32  store data, right-justified for sub-word stores.
- rdata  out  32  load result; valid while ack = 1.
- ack  out  1  one-cycle completion pulse.
- err  out  1  qualified by ack: request was rejected and no RAM write occurred.
- busy  out  1  high in any state other than IDLE.
- mem_addr  out  ADDR_W  RAM byte address (MSB byte at mem_addr).
- mem_wdata  out  32  RAM write data, [31:24] goes to mem_addr.
- mem_nRD  out  1  1 = RAM drives mem_dout, 0 = RAM output high-Z.
- mem_nWR  out  1  1 = RAM commits mem_wdata at the falling clk edge.
- mem_dout  in  32  RAM read data.

Behaviour:
- Reset values: state IDLE; rdata, mem_addr, mem_wdata = 0; ack, err, busy, mem_nRD, mem_nWR = 0.
- States: IDLE, RD, RMW_RD, WR, DONE.
- IDLE with req = 1: latch we/size/sext/addr/wdata, then compute base address.
  - Word: base = addr.
  - Sub-word: base = {addr[ADDR_W-1:2], 2'b00}.
- Error check, in IDLE: if size = 11 or base+3 >= RAM_BYTES, go to DONE with err = 1. No RAM access.
- Otherwise, next state:
  - Load: RD.
  - Word store: WR.
  - Sub-word store: RMW_RD.
- RD and RMW_RD:
  - mem_addr = base, mem_nRD = 1, mem_nWR = 0.
  - Capture mem_dout into an internal word register at the end of the cycle.
- Load extraction from the captured word (lane 0 = [31:24]):
  - Byte: lane addr[1:0].
  - Halfword: addr[1] selects [31:16] or [15:0]; addr[0] is ignored.
  - Extend per sext.
- RMW_RD -> WR: merge wdata[7:0] or wdata[15:0] into the selected lane; the other bytes are preserved.
- WR:
  - mem_addr = base, mem_wdata = merged or full word, mem_nWR = 1 for exactly one cycle, mem_nRD = 0.
  - The RAM commits at the mid-cycle negedge.
- DONE: ack = 1 and busy = 1 for one cycle, then IDLE. rdata is held until the next load completes.
- mem_nWR = 1 only in WR. mem_nRD = 1 only in RD or RMW_RD. mem_nRD and mem_nWR are never both high.
- Latency, counted from the accepting posedge to the ack cycle:
  - Error: 1 cycle.
  - Load or word store: 2 cycles.
  - Sub-word store: 3 cycles.
- Back-to-back: req may be high in the ack cycle, but it is only accepted on the following IDLE edge. A new request therefore starts at least one cycle after ack.
- req while busy: ignored, not queued.
- Reset mid-operation:
  - Asserted in RD or RMW_RD: no write ever occurs.
  - Asserted in WR: the negedge write within that cycle has already happened and completes; no ack is issued.
  - All outputs return to their reset values at the next posedge.

Optional Feature:
- Macro: MAU_ALIGN_CHECK_EN.
- Defined:
  - Word with addr[1:0] != 0 or halfword with addr[0] != 0 -> err path, 1-cycle latency, no RAM access.
- Undefined:
  - Unaligned word accesses go to RAM at the raw addr (bytes addr..addr+3).
  - Halfword addr[0] is ignored.

Test Plan:
- reset, then store word 0x12345678 to addr 8, then load word from addr 8 -> ack 2 cycles after acceptance each; rdata = 0x12345678; err = 0; exactly one mem_nWR pulse.
- After the above, store byte 0xAB to addr 9 -> mem_nRD for one cycle, then mem_nWR for one cycle at mem_addr 8 with mem_wdata 0x12AB5678; ack 3 cycles after acceptance.
- Load byte from addr 9 with sext = 1 -> rdata 0xFFFFFFAB; sext = 0 -> 0x000000AB. Load halfword from addr 10 with sext = 0 -> 0x00005678.
- Word store to addr 60, or size = 11 -> ack with err = 1 one cycle after acceptance; mem_nWR never asserted; prior RAM contents intact.
- Word load from addr 6:
  - With MAU_ALIGN_CHECK_EN: err = 1.
  - Without it: rdata = bytes 6..9 concatenated, mem_addr = 6.
- Reset asserted during RMW_RD of a byte store -> no mem_nWR pulse; outputs return to 0; the next word load of addr 8 returns the unmodified word.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: word/half/byte accesses to a
// byte-addressed big-endian data RAM, with read-modify-write for
// sub-word stores.
// Ports: clk, reset (sync, active high); CPU side req/we/size/sext/
// addr/wdata in, rdata/ack/err/busy out; RAM side mem_addr/
// mem_wdata/mem_nRD/mem_nWR out, mem_dout in.
// Build option: define MAU_ALIGN_CHECK_EN to reject misaligned
// word and halfword accesses.
module mem_access_unit #(
  parameter int RAM_BYTES = 61,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_nRD,
  output logic              mem_nWR,
  input  logic [31:0]       mem_dout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_WR     = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [1:0] SZ_W = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_B = 2'b10;

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(RAM_BYTES);

  logic [2:0]        state;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [1:0]        lane_q;
  logic [ADDR_W-1:0] base_q;
  logic [15:0]       wdata_q;
  logic [31:0]       word_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [ADDR_W-1:0] base_n;
  logic [ADDR_W:0]   last_n;
  logic              misalign;
  logic              bad;

  // Sub-word accesses always fetch the enclosing aligned word.
  assign base_n = (size == SZ_W) ? addr
                : {addr[ADDR_W-1:2], 2'b00};
  // One extra bit so a base near the top of the space cannot wrap.
  assign last_n = {1'b0, base_n} + (ADDR_W+1)'(3);

`ifdef MAU_ALIGN_CHECK_EN
  assign misalign = ((size == SZ_W) && (addr[1:0] != 2'b00))
                 || ((size == SZ_H) && addr[0]);
`else
  assign misalign = 1'b0;
`endif

  assign bad = (size == 2'b11) || (last_n >= LIMIT) || misalign;

  function automatic logic [31:0] extract(
    input logic [31:0] w,
    input logic [1:0]  sz,
    input logic [1:0]  ln,
    input logic        sx
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (ln)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = ln[1] ? w[15:0] : w[31:16];
    r = w;
    if (sz == SZ_B)
      r = {{24{sx & b[7]}}, b};
    else if (sz == SZ_H)
      r = {{16{sx & h[15]}}, h};
    return r;
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] w,
    input logic [15:0] d,
    input logic [1:0]  sz,
    input logic [1:0]  ln
  );
    logic [31:0] r;
    r = w;
    if (sz == SZ_H) begin
      if (ln[1]) r = {w[31:16], d};
      else       r = {d, w[15:0]};
    end else begin
      case (ln)
        2'd0:    r = {d[7:0], w[23:0]};
        2'd1:    r = {w[31:24], d[7:0], w[15:0]};
        2'd2:    r = {w[31:16], d[7:0], w[7:0]};
        default: r = {w[31:8], d[7:0]};
      endcase
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      size_q  <= '0;
      sext_q  <= 1'b0;
      lane_q  <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (req) begin
            size_q  <= size;
            sext_q  <= sext;
            lane_q  <= addr[1:0];
            base_q  <= base_n;
            wdata_q <= wdata[15:0];
            word_q  <= wdata;
            err_q   <= bad;
            if (bad)
              state <= S_DONE;
            else if (!we)
              state <= S_RD;
            else if (size == SZ_W)
              state <= S_WR;
            else
              state <= S_RMW_RD;
          end
        end
        (state == S_RD): begin
          word_q  <= mem_dout;
          rdata_q <= extract(mem_dout, size_q, lane_q, sext_q);
          state   <= S_DONE;
        end
        (state == S_RMW_RD): begin
          word_q <= merge(mem_dout, wdata_q, size_q, lane_q);
          state  <= S_WR;
        end
        (state == S_WR): begin
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign rdata     = rdata_q;
  assign busy      = (state != S_IDLE);
  assign ack       = (state == S_DONE);
  assign err       = ack & err_q;
  assign mem_nRD   = (state == S_RD) || (state == S_RMW_RD);
  assign mem_nWR   = (state == S_WR);
  assign mem_addr  = (mem_nRD || mem_nWR) ? base_q : '0;
  assign mem_wdata = mem_nWR ? word_q : 32'h0;

endmodule
